// File: rtl/icetap_pkg.sv
// Shared types and defaults for the icetap capture engine.
// The optional storage qualifier is enabled with ICETAP_STORAGE_QUAL_EN.
package icetap_pkg;

  localparam int unsigned ICETAP_STATE_BITS   = 3;
  localparam int unsigned ICETAP_NR_SIGNALS   = 16;
  localparam int unsigned ICETAP_RECORD_DEPTH = 256;
  localparam int unsigned ICETAP_CNT_BITS     = 16;

  typedef enum logic [ICETAP_STATE_BITS-1:0] {
    ICETAP_IDLE      = 3'd0,
    ICETAP_PRE_FILL  = 3'd1,
    ICETAP_WAIT_TRIG = 3'd2,
    ICETAP_POST_FILL = 3'd3,
    ICETAP_DONE      = 3'd4
  } icetap_state_e;

  // Pre-trigger window must leave room for the trigger sample and one post sample.
  function automatic int unsigned icetap_pretrig_clamp(input int unsigned len,
                                                       input int unsigned depth);
    return (len >= depth - 1) ? depth - 2 : len;
  endfunction

endpackage

// File: rtl/icetap_capture_if.sv
// Control, status and readout bundle between the icetap capture engine and its host.
// qual_mask/qual_value exist only when ICETAP_STORAGE_QUAL_EN is defined.
interface icetap_capture_if #(
  parameter int unsigned NR_SIGNALS = icetap_pkg::ICETAP_NR_SIGNALS,
  parameter int unsigned ADDR_BITS  = $clog2(icetap_pkg::ICETAP_RECORD_DEPTH),
  parameter int unsigned CNT_BITS   = icetap_pkg::ICETAP_CNT_BITS
);
  import icetap_pkg::*;

  logic [NR_SIGNALS-1:0]        signals_in;
  logic                         arm;
  logic                         abort;
  logic [NR_SIGNALS-1:0]        trig_mask;
  logic [NR_SIGNALS-1:0]        trig_value;
  logic [NR_SIGNALS-1:0]        trig_edge;
  logic [CNT_BITS-1:0]          trig_count;
  logic [ADDR_BITS-1:0]         pretrig_len;
  logic [ICETAP_STATE_BITS-1:0] state;
  logic                         done;
  logic [ADDR_BITS-1:0]         trig_addr;
  logic [ADDR_BITS-1:0]         start_addr;
  logic [ADDR_BITS-1:0]         rd_addr;
  logic [NR_SIGNALS-1:0]        rd_data;
`ifdef ICETAP_STORAGE_QUAL_EN
  logic [NR_SIGNALS-1:0]        qual_mask;
  logic [NR_SIGNALS-1:0]        qual_value;
`endif

  modport master (
    output signals_in, arm, abort, trig_mask, trig_value, trig_edge,
           trig_count, pretrig_len, rd_addr,
`ifdef ICETAP_STORAGE_QUAL_EN
    output qual_mask, qual_value,
`endif
    input  state, done, trig_addr, start_addr, rd_data
  );

  modport slave (
    input  signals_in, arm, abort, trig_mask, trig_value, trig_edge,
           trig_count, pretrig_len, rd_addr,
`ifdef ICETAP_STORAGE_QUAL_EN
    input  qual_mask, qual_value,
`endif
    output state, done, trig_addr, start_addr, rd_data
  );

endinterface

// File: rtl/icetap_ram.sv
// Simple dual-port sample memory: one write port, one registered read port.
// Read-during-write to the same address returns the previous contents.
module icetap_ram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register carries the reset; the array itself is never cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata <= '0;
    else       rdata <= mem[raddr];
  end

endmodule

// File: rtl/icetap_capture.sv
// icetap capture engine: circular sample recorder with masked level/edge trigger,
// occurrence count and pre-trigger window. ICETAP_STORAGE_QUAL_EN adds a storage qualifier.
module icetap_capture
  import icetap_pkg::*;
#(
  parameter int unsigned NR_SIGNALS   = ICETAP_NR_SIGNALS,
  parameter int unsigned RECORD_DEPTH = ICETAP_RECORD_DEPTH,
  parameter int unsigned CNT_BITS     = ICETAP_CNT_BITS
) (
  input  logic            clk,
  input  logic            reset,
  icetap_capture_if.slave bus
);

  localparam int unsigned ADDR_BITS = $clog2(RECORD_DEPTH);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(RECORD_DEPTH - 1);

  icetap_state_e         state_q, state_nx;
  logic [NR_SIGNALS-1:0] s_q, s_p;
  logic                  s_p_valid;
  logic [ADDR_BITS-1:0]  wr_addr, fill_cnt, remaining, pretrig_l;
  logic [ADDR_BITS-1:0]  trig_addr_q, start_addr_q;
  logic [CNT_BITS-1:0]   occ_cnt, trig_count_l;
  logic                  done_q;

  logic [NR_SIGNALS-1:0] lvl_ok, edge_ok, bit_ok;
  logic                  match, qual_ok;
  logic                  arm_go, hit, wr_en, pre_last, post_last, match_inc;
  logic [ADDR_BITS-1:0]  pretrig_arm, post_len;
  logic [CNT_BITS-1:0]   occ_target;

  // Arm-time configuration and derived limits.
  always_comb begin
    pretrig_arm = ADDR_BITS'(icetap_pretrig_clamp(32'(bus.pretrig_len), 32'(RECORD_DEPTH)));
    post_len    = LAST_ADDR - pretrig_l;
    occ_target  = (trig_count_l == '0) ? CNT_BITS'(1) : trig_count_l;
  end

  // Trigger match: every masked bit must pass its level or edge compare.
  always_comb begin
    lvl_ok  = ~(s_q ^ bus.trig_value);
    edge_ok = {NR_SIGNALS{s_p_valid}} & (s_p ^ s_q) & lvl_ok;
    bit_ok  = (bus.trig_edge & edge_ok) | (~bus.trig_edge & lvl_ok);
    match   = &(bit_ok | ~bus.trig_mask);
  end

`ifdef ICETAP_STORAGE_QUAL_EN
  assign qual_ok = ((s_q ^ bus.qual_value) & bus.qual_mask) == '0;
`else
  assign qual_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ICETAP_IDLE;
    else       state_q <= state_nx;
  end

  // Next-state logic; abort wins over everything.
  always_comb begin
    state_nx = state_q;
    if (bus.abort) begin
      state_nx = ICETAP_IDLE;
    end else begin
      case (state_q)
        ICETAP_IDLE, ICETAP_DONE: begin
          if (bus.arm) state_nx = (pretrig_arm == '0) ? ICETAP_WAIT_TRIG : ICETAP_PRE_FILL;
        end
        ICETAP_PRE_FILL: begin
          if (pre_last) state_nx = ICETAP_WAIT_TRIG;
        end
        ICETAP_WAIT_TRIG: begin
          if (hit) state_nx = (post_len == '0) ? ICETAP_DONE : ICETAP_POST_FILL;
        end
        ICETAP_POST_FILL: begin
          if (post_last) state_nx = ICETAP_DONE;
        end
        default: state_nx = ICETAP_IDLE;
      endcase
    end
  end

  // Per-state datapath controls.
  always_comb begin
    arm_go    = 1'b0;
    hit       = 1'b0;
    wr_en     = 1'b0;
    pre_last  = 1'b0;
    post_last = 1'b0;
    match_inc = 1'b0;
    case (state_q)
      ICETAP_IDLE, ICETAP_DONE: begin
        arm_go = bus.arm & ~bus.abort;
      end
      ICETAP_PRE_FILL: begin
        wr_en    = qual_ok;
        pre_last = wr_en & ((fill_cnt + ADDR_BITS'(1)) == pretrig_l);
      end
      ICETAP_WAIT_TRIG: begin
        match_inc = match & ~bus.abort;
        hit       = match_inc & ((occ_cnt + CNT_BITS'(1)) == occ_target);
        // The trigger sample is stored even when it fails the qualifier.
        wr_en     = qual_ok | hit;
      end
      ICETAP_POST_FILL: begin
        wr_en     = qual_ok;
        post_last = wr_en & (remaining <= ADDR_BITS'(1));
      end
      default: ;
    endcase
  end

  // Input stage: current and previous probe samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q       <= '0;
      s_p       <= '0;
      s_p_valid <= 1'b0;
    end else begin
      s_q       <= bus.signals_in;
      s_p       <= s_q;
      s_p_valid <= ~arm_go;
    end
  end

  // Capture counters, arm latch and trigger bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr      <= '0;
      fill_cnt     <= '0;
      remaining    <= '0;
      pretrig_l    <= '0;
      occ_cnt      <= '0;
      trig_count_l <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= (state_nx == ICETAP_DONE);
      if (arm_go) begin
        wr_addr      <= '0;
        fill_cnt     <= '0;
        occ_cnt      <= '0;
        pretrig_l    <= pretrig_arm;
        trig_count_l <= bus.trig_count;
      end else begin
        if (wr_en) wr_addr <= wr_addr + ADDR_BITS'(1);
        if (state_q == ICETAP_PRE_FILL && wr_en) fill_cnt <= fill_cnt + ADDR_BITS'(1);
        if (match_inc) occ_cnt <= occ_cnt + CNT_BITS'(1);
        if (hit) begin
          trig_addr_q  <= wr_addr;
          start_addr_q <= wr_addr - pretrig_l;
          remaining    <= post_len;
        end
        if (state_q == ICETAP_POST_FILL && wr_en) remaining <= remaining - ADDR_BITS'(1);
      end
    end
  end

  assign bus.state      = state_q;
  assign bus.done       = done_q;
  assign bus.trig_addr  = trig_addr_q;
  assign bus.start_addr = start_addr_q;

  icetap_ram #(
    .WIDTH(NR_SIGNALS),
    .DEPTH(RECORD_DEPTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (s_q),
    .raddr (bus.rd_addr),
    .rdata (bus.rd_data)
  );

endmodule

// File: tb/tb_icetap_capture.sv
// Scoreboarded bench for icetap_capture: captures are predicted from the recorded
// probe stream, then checked against done/trig_addr/start_addr and a full RAM readout.
module tb_icetap_capture;
  import icetap_pkg::*;

  localparam int NS = 8;
  localparam int D  = 16;
  localparam int AB = 4;
  localparam int CB = 8;
  localparam int L  = 128;

  logic clk = 1'b0;
  logic reset;

  icetap_capture_if #(.NR_SIGNALS(NS), .ADDR_BITS(AB), .CNT_BITS(CB)) bus ();

  icetap_capture #(.NR_SIGNALS(NS), .RECORD_DEPTH(D), .CNT_BITS(CB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int trig;
    int start;
    int lat;
  } cap_exp_t;

  cap_exp_t        cap_q[$];
  logic [NS-1:0]   rd_q[$];
  logic [NS-1:0]   xs[L];
  int              checks = 0;
  int              fails  = 0;
  logic            rd_en_tb = 1'b0;
  logic            rd_pend  = 1'b0;
  int              lat_cnt  = 0;
  logic            done_prev = 1'b0;
  cap_exp_t        mon_cap;
  logic [NS-1:0]   mon_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: does stream sample j satisfy the trigger condition?
  function automatic bit mdl_match(input int j, input logic [NS-1:0] m,
                                   input logic [NS-1:0] v, input logic [NS-1:0] e);
    for (int i = 0; i < NS; i++) begin
      if (m[i]) begin
        if (xs[j][i] != v[i]) return 1'b0;
        if (e[i] && (j == 0 || xs[j-1][i] == xs[j][i])) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  // Reference: stream index of the trigger sample, or -1.
  function automatic int mdl_trigger(input int pe, input logic [NS-1:0] m,
                                     input logic [NS-1:0] v, input logic [NS-1:0] e,
                                     input int n);
    int need = (n == 0) ? 1 : n;
    int seen = 0;
    for (int j = pe; j < L; j++) begin
      if (mdl_match(j, m, v, e)) begin
        seen++;
        if (seen == need) return j;
      end
    end
    return -1;
  endfunction

  task automatic gen_pattern(input int pat);
    for (int j = 0; j < L; j++) begin
      case (pat)
        0:       xs[j] = NS'(j + 1);
        1:       xs[j] = NS'(((j >> 1) & 1) << 1);
        2:       xs[j] = NS'($urandom & 32'hF);
        default: xs[j] = '0;
      endcase
    end
  endtask

  task automatic run_capture(input int p, input logic [NS-1:0] m, input logic [NS-1:0] v,
                             input logic [NS-1:0] e, input int n, input int pat);
    int pe = (p >= D - 1) ? D - 2 : p;
    int k;
    int w;
    int t;
    logic [NS-1:0] mm = m;
    gen_pattern(pat);
    k = mdl_trigger(pe, mm, v, e, n);
    for (int tries = 0; tries < 20 && (k < 0 || k + D - pe > L); tries++) begin
      gen_pattern(pat);
      k = mdl_trigger(pe, mm, v, e, n);
    end
    if (k < 0 || k + D - pe > L) begin
      mm = '0;
      k  = mdl_trigger(pe, mm, v, e, n);
    end
    w = k + D - pe;
    cap_q.push_back('{k % D, (k - pe) % D, w});

    bus.trig_mask   = mm;
    bus.trig_value  = v;
    bus.trig_edge   = e;
    bus.trig_count  = CB'(n);
    bus.pretrig_len = AB'(p);
    bus.arm         = 1'b1;
    bus.signals_in  = xs[0];
    step();
    bus.arm = 1'b0;
    for (int j = 1; j < w; j++) begin
      bus.signals_in = xs[j];
      step();
    end
    bus.signals_in = NS'($urandom);
    t = 0;
    while (!bus.done && t < 60) begin
      step();
      t++;
    end
    if (!bus.done) begin
      checks++;
      fails++;
      $display("FAIL done_timeout actual=0 required=1");
      void'(cap_q.pop_back());
      return;
    end
    for (int i = 0; i < D; i++) begin
      bus.rd_addr = AB'((k - pe + i) % D);
      rd_q.push_back(xs[k - pe + i]);
      rd_en_tb = 1'b1;
      step();
    end
    rd_en_tb = 1'b0;
    step();
    step();
  endtask

  // Monitor bookkeeping on the active edge (inputs change 1 time unit later).
  always @(posedge clk) begin
    rd_pend <= rd_en_tb;
    if (bus.arm && !bus.abort) lat_cnt <= 0;
    else                       lat_cnt <= lat_cnt + 1;
  end

  // Scoreboard: compare DUT outputs when it presents a read result or completes a capture.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL rd_unexpected actual=%0h required=none", bus.rd_data);
      end else begin
        mon_rd = rd_q.pop_front();
        chk("rd_data", 32'(bus.rd_data), 32'(mon_rd));
      end
    end
    if (bus.done && !done_prev) begin
      if (cap_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL done_unexpected actual=1 required=0");
      end else begin
        mon_cap = cap_q.pop_front();
        chk("trig_addr", 32'(bus.trig_addr), 32'(mon_cap.trig));
        chk("start_addr", 32'(bus.start_addr), 32'(mon_cap.start));
        chk("done_latency", 32'(lat_cnt), 32'(mon_cap.lat));
      end
    end
    done_prev = bus.done;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    bus.signals_in  = '0;
    bus.arm         = 1'b0;
    bus.abort       = 1'b0;
    bus.trig_mask   = '0;
    bus.trig_value  = '0;
    bus.trig_edge   = '0;
    bus.trig_count  = '0;
    bus.pretrig_len = '0;
    bus.rd_addr     = '0;
`ifdef ICETAP_STORAGE_QUAL_EN
    bus.qual_mask   = '0;
    bus.qual_value  = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(bus.state), 32'(ICETAP_IDLE));
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_trig_addr", 32'(bus.trig_addr), 32'd0);
    chk("reset_start_addr", 32'(bus.start_addr), 32'd0);
    chk("reset_rd_data", 32'(bus.rd_data), 32'd0);
    reset = 1'b0;
    step();

    run_capture(4, 8'h01, 8'h01, 8'h00, 0, 0);   // level trigger, counter stream
    run_capture(0, 8'h02, 8'h02, 8'h02, 3, 1);   // third rising edge of bit1
    run_capture(0, 8'h00, 8'h00, 8'h00, 0, 0);   // immediate trigger
    run_capture(15, 8'h00, 8'h00, 8'h00, 1, 0);  // pre-trigger clamp
    for (int r = 0; r < 8; r++) begin
      logic [NS-1:0] m;
      m = NS'($urandom & 32'hF);
      run_capture($urandom_range(0, 15), m, NS'($urandom), NS'($urandom) & m,
                  $urandom_range(0, 3), 2);
    end

    // Abort in POST_FILL, then arm+abort together.
    bus.trig_mask   = '0;
    bus.pretrig_len = '0;
    bus.arm         = 1'b1;
    step();
    bus.arm = 1'b0;
    chk("abort_pre_state", 32'(bus.state), 32'(ICETAP_WAIT_TRIG));
    step();
    chk("abort_post_state", 32'(bus.state), 32'(ICETAP_POST_FILL));
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_state", 32'(bus.state), 32'(ICETAP_IDLE));
    chk("abort_done", 32'(bus.done), 32'd0);
    bus.arm   = 1'b1;
    bus.abort = 1'b1;
    step();
    bus.arm   = 1'b0;
    bus.abort = 1'b0;
    chk("arm_abort_state", 32'(bus.state), 32'(ICETAP_IDLE));
    step();

    run_capture(4, 8'hFF, 8'd41, 8'h00, 1, 0);  // trigger held off until stream index 40

    // Async reset while waiting for an unreachable trigger.
    bus.signals_in  = '0;
    bus.trig_mask   = 8'hFF;
    bus.trig_value  = 8'hAA;
    bus.trig_edge   = '0;
    bus.pretrig_len = AB'(2);
    bus.arm         = 1'b1;
    step();
    bus.arm = 1'b0;
    step();
    step();
    chk("wait_before_reset", 32'(bus.state), 32'(ICETAP_WAIT_TRIG));
    #2 reset = 1'b1;
    #1;
    chk("midrst_state", 32'(bus.state), 32'(ICETAP_IDLE));
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_trig_addr", 32'(bus.trig_addr), 32'd0);
    chk("midrst_start_addr", 32'(bus.start_addr), 32'd0);
    chk("midrst_rd_data", 32'(bus.rd_data), 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("post_reset_state", 32'(bus.state), 32'(ICETAP_IDLE));

    chk("cap_queue_drained", 32'(cap_q.size()), 32'd0);
    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
